key_conditioner: RTL and testbench
==================================

# key_conditioner

Input-conditioning stage between the board push-buttons and the game logic's `keys_i` input. It does three things per key:
- synchronises each raw key into `clk_i` and removes contact bounce with a per-key stability counter;
- presents clean active-high levels on `keys_o`;
- emits single-cycle press and release pulses.

Game logic consumes either the levels (held paddle movement) or the pulses (serve/start), so it never sees metastable or bouncing inputs.

## Interface
Parameters:
- `KEYS_W`, default `board_pkg::KEYS_W`: number of keys.
- `KEY_ACTIVE_LOW`, default 1: 1 means a raw key reads 0 when pressed.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a change. Minimum 2.
- `REPEAT_DELAY_CYCLES`, default 25000000: hold time before the first auto-repeat pulse. Minimum 2. Used only with repeat enabled.
- `REPEAT_RATE_CYCLES`, default 5000000: spacing of subsequent auto-repeat pulses. Minimum 2. Used only with repeat enabled.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `keys_i`  in  `KEYS_W`  raw asynchronous key inputs.
- `keys_o`  out  `KEYS_W`  debounced level, active-high (1 = pressed).
- `press_o`  out  `KEYS_W`  one-cycle pulse per accepted press (plus auto-repeat pulses if enabled).
- `release_o`  out  `KEYS_W`  one-cycle pulse per accepted release.

## Operation
- Each key is fully independent. All per-key logic is replicated with a generate loop.
- **Polarity:** the raw input is XORed with `KEY_ACTIVE_LOW` before synchronisation, so all internal logic is active-high.
- **Synchroniser:** two flops, `s1` then `s2`.
- **Debounce:** `stable` register plus counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - While `s2 == stable`: `cnt` is held at 0.
  - While `s2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` increments.
  - When `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`.
  - Any return of `s2` to `stable` before acceptance restarts the count from 0. Bounces shorter than `DEBOUNCE_CYCLES` are fully rejected.
- **Level output:** `keys_o` is `stable`, driven directly from the register.
- **Edge pulses:** `press_o[k]` and `release_o[k]` are registered. Each is high for exactly the one cycle in which `stable[k]` has just changed 0→1 (press) or 1→0 (release). The two never assert together for the same key.
- **Per-key state machine:** RELEASED → PRESS_PEND → PRESSED → RELEASE_PEND → RELEASED.
  - A pending state returns to its origin state if `s2` reverts before the count completes.
- **Counter widths:** all counters saturate by construction and never wrap, since they are compared and cleared at their terminal value.

## Timing
- **Reset (`rst_i` low, asynchronous):**
  - `s1`, `s2`, `stable`, `cnt`, repeat counter all 0 (i.e. released after polarity correction).
  - `keys_o`, `press_o`, `release_o` all 0.
- **Latency:** a raw change held steady is reflected on `keys_o` exactly `DEBOUNCE_CYCLES + 2` rising edges after the first edge that samples it. `press_o`/`release_o` assert in the same cycle `keys_o` changes.
- **Held key at reset release:** a key already pressed when `rst_i` deasserts is treated as a fresh press. `press_o` pulses `DEBOUNCE_CYCLES + 2` edges after reset release.
- **Reset mid-debounce:** all progress is discarded and no pulse is emitted.
- **Simultaneous keys:** several keys may pulse in the same cycle. There is no arbitration.

## Configuration
- Macro `KEY_CONDITIONER_REPEAT_EN`.
- **Defined:** a per-key repeat counter runs while `stable` is 1.
  - The first extra `press_o` pulse comes `REPEAT_DELAY_CYCLES` cycles after the initial press pulse.
  - Further pulses follow every `REPEAT_RATE_CYCLES` cycles while the key stays held.
  - The repeat counter clears on release or reset. `release_o` is unaffected.
- **Undefined:** there is no repeat counter and `press_o` pulses only once per press. The `REPEAT_*` parameters are ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY_CYCLES=10`, `REPEAT_RATE_CYCLES=3`, `KEY_ACTIVE_LOW=1`, `KEYS_W=4`.

1. **Clean press:** `keys_i` = 4'b1111, then 4'b1110 held.
   - `keys_o[0]` rises on edge 6 after the change.
   - `press_o[0]` is high for exactly that cycle.
   - Other bits stay 0.
2. **Bounce rejection:** `keys_i[1]` low for 3 cycles, high for 2, low for 3, then high.
   - `keys_o[1]` stays 0.
   - `press_o[1]` and `release_o[1]` never assert.
3. **Release:** after scenario 1, set `keys_i[0]`=1.
   - `keys_o[0]` falls 6 edges later with a one-cycle `release_o[0]`.
   - No `press_o`.
4. **Auto-repeat (macro defined):** hold key 2 for 30 cycles after acceptance.
   - `press_o[2]` pulses at accept+0, +10, +13, +16, …, +28.
   - Released when the key is let go.
   - With the macro undefined, only the accept+0 pulse occurs.
5. **Reset mid-operation:** hold key 3, pull `rst_i` low 2 cycles before acceptance.
   - All outputs are 0 immediately.
   - After release of `rst_i` with the key still held, `press_o[3]` pulses 6 edges later.
6. **Simultaneous:** keys 0 and 3 pressed in the same cycle.
   - Both `press_o` bits pulse in the same cycle, on edge 6.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: push-button input conditioning for the game logic.
// For each key the block runs polarity correction, a two-flop
// synchroniser, a debounce state machine with a stability counter,
// and registered one-cycle press/release pulses.
// Optional feature macro: KEY_CONDITIONER_REPEAT_EN. When it is defined,
// a held key also produces auto-repeat press pulses.
// KEYS_W defaults to the board's four keys.
module key_conditioner #(
  parameter int KEYS_W              = 4,
  parameter int KEY_ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES     = 250000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] press_o,
  output logic [KEYS_W-1:0] release_o
);

  // Bit 1 of the state encoding is the accepted (stable) level,
  // so keys_o comes straight from the state register.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_PEND   = 2'b01,
    ST_PRESSED      = 2'b11,
    ST_RELEASE_PEND = 2'b10
  } state_t;

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            POL      = (KEY_ACTIVE_LOW != 0);

`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam int               RPT_MAX   = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                           REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int               RPT_W     = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);
`endif

  // Reject configurations that the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_bad_param
    $error("key_conditioner: cycle parameters must be at least 2");
  end

  for (genvar k = 0; k < KEYS_W; k++) begin : g_key
    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             stable;
`ifdef KEY_CONDITIONER_REPEAT_EN
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
`endif

    assign stable       = state_q[1];
    assign keys_o[k]    = stable;
    assign press_o[k]   = press_q;
    assign release_o[k] = release_q;

    // Polarity-corrected two-flop synchroniser; reset reads as released.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= keys_i[k] ^ POL;
        s2_q <= s1_q;
      end
    end

    // Debounce state, stability counter and registered edge pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state_q   <= ST_RELEASED;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

`ifdef KEY_CONDITIONER_REPEAT_EN
    // Auto-repeat counter: first interval is the delay, later ones the rate.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        rpt_q       <= '0;
        rpt_first_q <= 1'b1;
      end else begin
        rpt_q       <= rpt_d;
        rpt_first_q <= rpt_first_d;
      end
    end
`endif

    // Next state: a pending state commits after DEBOUNCE_CYCLES
    // consecutive disagreeing samples, or falls back when s2 reverts.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        ST_RELEASED, ST_PRESS_PEND: begin
          if (!s2_q) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            state_d = ST_PRESS_PEND;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_PRESSED, ST_RELEASE_PEND: begin
          if (s2_q) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = ST_RELEASED;
            cnt_d     = '0;
            release_d = 1'b1;
          end else begin
            state_d = ST_RELEASE_PEND;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
`ifdef KEY_CONDITIONER_REPEAT_EN
      // Runs only while the key stays accepted-pressed across this edge,
      // so a repeat pulse can never coincide with a release pulse.
      rpt_d       = '0;
      rpt_first_d = 1'b1;
      if (stable && state_d[1]) begin
        if (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_RATE_LAST)) begin
          press_d     = 1'b1;
          rpt_d       = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d       = rpt_q + RPT_W'(1);
          rpt_first_d = rpt_first_q;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: a vector table for the basic
// press/release/bounce cases, hand sequences for repeat, reset and
// simultaneous keys, and randomized stimulus against a behavioural model.
module tb_key_conditioner;
  localparam int KW = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] keys_i = '1;
  logic [KW-1:0] keys_o, press_o, release_o;

  int total = 0;
  int bad   = 0;

  key_conditioner #(
    .KEYS_W(KW), .KEY_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD), .REPEAT_RATE_CYCLES(RR)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .keys_i(keys_i),
    .keys_o(keys_o), .press_o(press_o), .release_o(release_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a key level is accepted once the synchronised
  // sample has disagreed with it for D consecutive edges. Repeat pulses
  // fall at RD edges after acceptance and every RR edges after that.
  logic [KW-1:0] m_stable = '0, m_press = '0, m_rel = '0;
  bit            r1[KW], r2[KW];
  int            run[KW], held[KW];

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_stable = '0; m_press = '0; m_rel = '0;
        for (int k = 0; k < KW; k++) begin
          r1[k] = 0; r2[k] = 0; run[k] = 0; held[k] = 0;
        end
      end else begin
        for (int k = 0; k < KW; k++) begin
          bit seen, accepted;
          seen     = r2[k];
          r2[k]    = r1[k];
          r1[k]    = ~keys_i[k];
          accepted = 0;
          m_press[k] = 1'b0;
          m_rel[k]   = 1'b0;
          if (seen != m_stable[k]) begin
            run[k]++;
            if (run[k] == D) begin
              m_stable[k] = seen;
              run[k]      = 0;
              m_press[k]  = seen;
              m_rel[k]    = !seen;
              held[k]     = 0;
              accepted    = 1;
            end
          end else begin
            run[k] = 0;
          end
`ifdef KEY_CONDITIONER_REPEAT_EN
          if (!accepted && m_stable[k]) begin
            held[k]++;
            if (held[k] == RD || (held[k] > RD && (held[k] - RD) % RR == 0))
              m_press[k] = 1'b1;
          end
`else
          if (!accepted && m_stable[k]) held[k]++;
`endif
        end
      end
    end
  end

  // Continuous comparison against the model, just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_keys_o", 32'(keys_o), 32'(m_stable));
      check("model_press_o", 32'(press_o), 32'(m_press));
      check("model_release_o", 32'(release_o), 32'(m_rel));
    end
  end

  typedef struct {
    logic          rst;
    logic [KW-1:0] keys;
    logic [KW-1:0] ko;
    logic [KW-1:0] pr;
    logic [KW-1:0] rl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int n, input logic rst, input logic [KW-1:0] keys,
                              input logic [KW-1:0] ko, input logic [KW-1:0] pr,
                              input logic [KW-1:0] rl);
    vec_t v;
    v.rst = rst; v.keys = keys; v.ko = ko; v.pr = pr; v.rl = rl;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endfunction

  // Waits up to 40 edges for a pulse on one key; lat stays 0 if no pulse arrives.
  task automatic wait_pulse(input int idx, input bit is_press, output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #2;
      if (is_press ? press_o[idx] : release_o[idx]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  initial begin
    int            lat;
    logic [31:0]   mask, exp_mask;

    // Reset, clean press of key 0, release, then bounce on key 1.
    add(2, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(2, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(5, 1'b1, 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1'b1, 4'b1110, 4'b0001, 4'b0001, 4'b0000);
    add(1, 1'b1, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
    add(5, 1'b1, 4'b1111, 4'b0001, 4'b0000, 4'b0000);
    add(1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
    add(1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(3, 1'b1, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
    add(2, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(3, 1'b1, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
    add(4, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n  = tbl[i].rst;
      keys_i = tbl[i].keys;
      @(posedge clk);
      #2;
      check($sformatf("tbl%0d_keys_o", i), 32'(keys_o), 32'(tbl[i].ko));
      check($sformatf("tbl%0d_press_o", i), 32'(press_o), 32'(tbl[i].pr));
      check($sformatf("tbl%0d_release_o", i), 32'(release_o), 32'(tbl[i].rl));
    end

    // Auto-repeat on key 2: pulse offsets over 30 edges after acceptance.
    @(negedge clk);
    keys_i = 4'b1011;
    wait_pulse(2, 1'b1, lat);
    check("repeat_first_latency", 32'(lat), 32'd6);
    mask = '0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      #2;
      if (press_o[2]) mask[j] = 1'b1;
    end
    exp_mask = '0;
`ifdef KEY_CONDITIONER_REPEAT_EN
    for (int j = RD; j <= 30; j += RR) exp_mask[j] = 1'b1;
`endif
    check("repeat_offsets", mask, exp_mask);
    @(negedge clk);
    keys_i = 4'b1111;
    wait_pulse(2, 1'b0, lat);
    check("repeat_release_latency", 32'(lat), 32'd6);
    idle(4);

    // Reset in the middle of key 3's debounce while key 0 is held.
    @(negedge clk);
    keys_i = 4'b1110;
    idle(7);
    @(negedge clk);
    check("pre_reset_keys_o", 32'(keys_o), 32'h1);
    keys_i = 4'b0110;
    idle(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {keys_o, press_o, release_o}, 32'h0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(3, 1'b1, lat);
    check("post_reset_press_latency", 32'(lat), 32'd6);
    check("post_reset_press_both", 32'(press_o), 32'h9);
    @(negedge clk);
    keys_i = 4'b1111;
    idle(10);

    // Keys 0 and 3 together.
    @(negedge clk);
    keys_i = 4'b0110;
    wait_pulse(0, 1'b1, lat);
    check("simul_latency", 32'(lat), 32'd6);
    check("simul_press_bits", 32'(press_o), 32'h9);
    @(negedge clk);
    keys_i = 4'b1111;
    idle(10);

    // Randomized presses, bounces and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) != 0);
      for (int k = 0; k < KW; k++)
        if ($urandom_range(0, (c < 1500) ? 7 : 30) == 0) keys_i[k] = ~keys_i[k];
    end
    idle(3);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
